// File: rtl/riscv_alu_pkg.sv
// Shared ALU definitions: divide-class aluc codes, divider FSM states and operand helpers.
package riscv_alu_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [4:0] ALUC_DIV  = 5'd20;
  localparam logic [4:0] ALUC_DIVU = 5'd21;
  localparam logic [4:0] ALUC_REM  = 5'd22;
  localparam logic [4:0] ALUC_REMU = 5'd23;

  localparam logic [XLEN-1:0] INT_MIN  = 32'h8000_0000;
  localparam logic [XLEN-1:0] ALL_ONES = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StSpecial} div_state_e;

  // Codes 20..23 share the prefix 3'b101; bit 1 selects remainder, bit 0 unsigned.
  function automatic logic is_div_op(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

  // abs(INT_MIN) wraps back to INT_MIN, which is the correct unsigned magnitude.
  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] x, input logic is_signed);
    return (is_signed && x[XLEN-1]) ? -x : x;
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
module div_unit
  import riscv_alu_pkg::*;
#(
  parameter int unsigned XLEN  = riscv_alu_pkg::XLEN,
  parameter int unsigned CNT_W = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] result,
  output logic            ready
);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dsr_q, dsr_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        op_q, op_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;

  logic              accept, signed_op, div_zero, ovf, borrow;
  logic [XLEN:0]     rem_sh;
  logic [XLEN+1:0]   trial;

  assign accept    = (state_q == StIdle) && start && is_div_op(op);
  assign signed_op = (op == ALUC_DIV) || (op == ALUC_REM);
  assign div_zero  = (divisor == '0);
  assign ovf       = signed_op && (dividend == INT_MIN) && (divisor == ALL_ONES);

  // Shift {rem,quo} left by one and trial-subtract; the extra top bit is the borrow.
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign trial  = {1'b0, rem_sh} - {2'b00, dsr_q};
  assign borrow = trial[XLEN+1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dsr_d    = dsr_q;
    result_d = result_q;
    op_d     = op_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d = op;
          if (div_zero || ovf) begin
            state_d = StSpecial;
            // The special-case answer is parked in the quotient register.
            if (div_zero) quo_d = op[1] ? dividend : ALL_ONES;
            else          quo_d = op[1] ? '0 : INT_MIN;
          end else begin
            state_d = StCalc;
            rem_d   = '0;
            quo_d   = mag(dividend, signed_op);
            dsr_d   = mag(divisor, signed_op);
            cnt_d   = CNT_W'(XLEN);
            qneg_d  = signed_op && (dividend[XLEN-1] ^ divisor[XLEN-1]);
            rneg_d  = signed_op && dividend[XLEN-1];
          end
        end
      end
      StCalc: begin
        if (borrow) begin
          rem_d = rem_sh[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b0};
        end else begin
          rem_d = trial[XLEN-1:0];
          quo_d = {quo_q[XLEN-2:0], 1'b1};
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StFix;
      end
      StFix: begin
        if (op_q[1]) result_d = rneg_q ? -rem_q : rem_q;
        else         result_d = qneg_q ? -quo_q : quo_q;
        state_d = StIdle;
      end
      StSpecial: begin
        result_d = quo_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dsr_q    <= '0;
      result_q <= '0;
      op_q     <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dsr_q    <= dsr_d;
      result_q <= result_d;
      op_q     <= op_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign result = result_q;
  assign ready  = (state_q == StIdle);

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed cases plus randomized ops against an arithmetic model.
module tb_div_unit;
  import riscv_alu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op = '0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] result;
  logic        ready;

  always #5 CLK = ~CLK;

  div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .start    (start),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .ready    (ready)
  );

  typedef struct {
    logic [31:0] res;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Plain 64-bit arithmetic; INT_MIN/-1 naturally truncates to INT_MIN with remainder 0.
  function automatic logic [31:0] ref_result(input logic [4:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sd;
    bit     sgn, isdiv;
    sgn   = (o == ALUC_DIV) || (o == ALUC_REM);
    isdiv = (o == ALUC_DIV) || (o == ALUC_DIVU);
    if (b == 32'd0) return isdiv ? 32'hFFFF_FFFF : a;
    if (sgn) begin
      sa = longint'($signed(a));
      sd = longint'($signed(b));
      return isdiv ? 32'(sa / sd) : 32'(sa % sd);
    end
    return isdiv ? a / b : a % b;
  endfunction

  function automatic int ref_latency(input logic [4:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    bit sgn;
    sgn = (o == ALUC_DIV) || (o == ALUC_REM);
    if (b == 32'd0 || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
    return 33;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!ready) begin
      checks++;
      $display("FAIL ready_timeout: ready still %0b after %0d cycles, expected 1", ready, n);
    end
  endtask

  // Called at a negedge; drives a request for the next rising edge.
  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    exp_t e;
    wait_ready();
    op       = o;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.res  = ref_result(o, a, b);
    e.lat  = ref_latency(o, a, b);
    e.name = name;
    sb.push_back(e);
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Monitor: counts busy cycles and checks each completion against the scoreboard head.
  initial begin : monitor
    int   busy = 0;
    logic prev = 1'b1;
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        busy = 0;
        prev = 1'b1;
      end else begin
        if (!ready) busy++;
        else if (!prev) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_completion: result 0x%08h with empty scoreboard", result);
          end else begin
            e = sb.pop_front();
            check(e.name, result, e.res);
            check({e.name, "_latency"}, 32'(busy), 32'(e.lat));
          end
          busy = 0;
        end
        prev = ready;
      end
    end
  end

  initial begin : stimulus
    logic [4:0]  o;
    logic [31:0] a, b;

    #2;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_result", result, 32'd0);
    #20 RESET = 1'b1;
    @(negedge CLK);
    check("post_reset_ready", {31'd0, ready}, 32'd1);
    check("post_reset_result", result, 32'd0);

    issue(ALUC_DIV,  32'd100,        32'd3,        "div_100_3");
    issue(ALUC_DIVU, 32'hFFFF_FFFE,  32'd2,        "divu_big_2");
    issue(ALUC_DIV,  32'hFFFF_FFF9,  32'd2,        "div_m7_2");
    issue(ALUC_REM,  32'hFFFF_FFF9,  32'd2,        "rem_m7_2");
    issue(ALUC_REMU, 32'd100,        32'd3,        "remu_100_3");
    issue(ALUC_DIV,  32'h8000_0000,  32'hFFFF_FFFF, "div_overflow");
    issue(ALUC_REM,  32'h8000_0000,  32'hFFFF_FFFF, "rem_overflow");
    issue(ALUC_DIV,  32'd123,        32'd0,        "div_by_zero");
    issue(ALUC_DIVU, 32'd123,        32'd0,        "divu_by_zero");
    issue(ALUC_REM,  32'd123,        32'd0,        "rem_by_zero");
    issue(ALUC_REMU, 32'd123,        32'd0,        "remu_by_zero");

    // Requests and operand changes while busy must be ignored.
    issue(ALUC_DIV, 32'd100, 32'd3, "div_busy_ignore");
    repeat (3) @(negedge CLK);
    op = ALUC_REMU; dividend = 32'd55; divisor = 32'd5; start = 1'b1;
    @(negedge CLK);
    start = 1'b0; dividend = 32'd9; divisor = 32'd0;
    wait_ready();
    @(negedge CLK);

    // Non-divide aluc in idle leaves the block idle with result untouched.
    op = 5'd5; dividend = 32'd7; divisor = 32'd0; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    check("bad_op_ready", {31'd0, ready}, 32'd1);
    check("bad_op_result", result, 32'd33);
    @(negedge CLK);
    check("bad_op_ready_later", {31'd0, ready}, 32'd1);

    // Asynchronous reset mid-operation discards the pending divide.
    issue(ALUC_DIV, 32'd1000, 32'd7, "div_aborted");
    repeat (8) @(negedge CLK);
    #2;
    sb.delete();
    RESET = 1'b0;
    #1;
    check("midop_reset_ready", {31'd0, ready}, 32'd1);
    check("midop_reset_result", result, 32'd0);
    @(negedge CLK);
    #2 RESET = 1'b1;
    @(negedge CLK);
    issue(ALUC_DIV, 32'd1000, 32'd7, "div_1000_7");

    for (int i = 0; i < 150; i++) begin
      o = 5'(20 + $urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = $urandom_range(0, 50);
        2:       a = -$urandom_range(1, 50);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2, 3:    b = $urandom_range(1, 15);
        4:       b = -$urandom_range(1, 15);
        default: b = $urandom;
      endcase
      issue(o, a, b, "random");
    end

    wait_ready();
    @(negedge CLK);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
